// File: rtl/stage1_pkg.sv
// Shared stage1 datapath definitions: RAM geometry, command op codes, sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stage1_pkg;

  localparam int RAM_ADDR_W = 6;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_DEPTH  = 64;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_ctrl_if.sv
// Command/response bundle between the control FSM (master) and ram_ctrl (slave).
// Latency: n/a (wires only).
// Backpressure: cmd_valid/cmd_ready on the command side; rsp_valid has no back-pressure.
interface ram_ctrl_if
  import stage1_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);

  logic              cmd_valid;
  op_t               cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/ram_ctrl.sv
// Single-command sequencer for the 64x32 RAM: WRITE, READ (RD_LAT aware), CLEAR sweep, NOP.
// Latency: write 2, read 2+RD_LAT, clear DEPTH+1, nop 1 cycles accept-to-accept; all outputs registered.
// Backpressure: cmd_ready low while a command is in flight; rsp_valid is a one-cycle pulse, never stalled.
module ram_ctrl
  import stage1_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int DEPTH  = RAM_DEPTH,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  ram_ctrl_if.slave         cmd,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q
);

  // Sweep ends on an explicit compare so a DEPTH below 2**ADDR_W still stops correctly.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        LAT_LOAD  = 2'(RD_LAT);

  state_t            state_q, state_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic              cmd_ready_d;
  logic              rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic              ram_wren_d;
  logic [DATA_W-1:0] ram_wdata_d;
  logic              accept;

  assign accept = cmd.cmd_valid && cmd.cmd_ready;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and next values of every registered output; RAM controls are set up one
  // cycle ahead so they are already on the pins during the state they belong to.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    cmd_ready_d = cmd.cmd_ready;
    rsp_valid_d = 1'b0;
    rsp_data_d  = cmd.rsp_data;
    ram_addr_d  = ram_addr;
    ram_wren_d  = 1'b0;
    ram_wdata_d = ram_wdata;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          case (cmd.cmd_op)
            OP_WRITE: begin
              state_d     = ST_WRITE;
              ram_addr_d  = cmd.cmd_addr;
              ram_wdata_d = cmd.cmd_data;
              ram_wren_d  = 1'b1;
            end
            OP_READ: begin
              state_d    = ST_READ;
              ram_addr_d = cmd.cmd_addr;
              lat_cnt_d  = LAT_LOAD;
            end
            OP_CLEAR: begin
              state_d     = ST_CLEAR;
              ram_addr_d  = '0;
              ram_wdata_d = cmd.cmd_data;
              ram_wren_d  = 1'b1;
            end
            default: begin
              // NOP completes immediately without touching the RAM.
              state_d     = ST_DONE;
              cmd_ready_d = 1'b1;
              rsp_valid_d = 1'b1;
            end
          endcase
        end
      end

      ST_WRITE: begin
        state_d     = ST_DONE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b1;
      end

      ST_READ: begin
        if (lat_cnt_q == 2'd0) begin
          state_d     = ST_DONE;
          rsp_data_d  = ram_q;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end

      ST_CLEAR: begin
        if (ram_addr == LAST_ADDR) begin
          state_d     = ST_DONE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
        end else begin
          ram_addr_d = ram_addr + ADDR_W'(1);
          ram_wren_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // Output and counter registers; reset abandons any command mid-flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_cnt_q     <= 2'd0;
      cmd.cmd_ready <= 1'b1;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_data  <= '0;
      ram_addr      <= '0;
      ram_wren      <= 1'b0;
      ram_wdata     <= '0;
    end else begin
      lat_cnt_q     <= lat_cnt_d;
      cmd.cmd_ready <= cmd_ready_d;
      cmd.rsp_valid <= rsp_valid_d;
      cmd.rsp_data  <= rsp_data_d;
      ram_addr      <= ram_addr_d;
      ram_wren      <= ram_wren_d;
      ram_wdata     <= ram_wdata_d;
    end
  end

endmodule
